// File: rtl/amba3_apb_slave_regs_pkg.sv
// Shared types and limits for the APB3 completer register bank.
package amba3_apb_slave_regs_pkg;

    typedef enum logic [1:0] {
        APB_S_IDLE,
        APB_S_WAIT,
        APB_S_DONE
    } amba3_apb_slave_state_t;

    localparam int unsigned APB_MAX_WAIT = 15;
    localparam int unsigned APB_CNT_W    = 4;

endpackage

// File: rtl/amba3_apb_slave_regs.sv
// APB3 completer: NUM_REGS x DATA_SIZE register bank with programmable wait states
// and PSLVERR on out-of-range word indices.
module amba3_apb_slave_regs
    import amba3_apb_slave_regs_pkg::*;
#(
    parameter int unsigned ADDR_SIZE   = 32,
    parameter int unsigned DATA_SIZE   = 32,
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                          pclk,
    input  logic                          preset,
    input  logic [ADDR_SIZE-1:0]          paddr,
    input  logic                          psel,
    input  logic                          penable,
    input  logic                          pwrite,
    input  logic [DATA_SIZE-1:0]          pwdata,
    output logic                          pready,
    output logic [DATA_SIZE-1:0]          prdata,
    output logic                          pslverr,
    output logic [NUM_REGS*DATA_SIZE-1:0] regs_o
);

    localparam int unsigned LSB      = $clog2(DATA_SIZE / 8);
    localparam int unsigned IDX_W    = ADDR_SIZE - LSB;
    localparam int unsigned CNT_LOAD = (WAIT_STATES == 0) ? 0 : WAIT_STATES - 1;

    if (WAIT_STATES > APB_MAX_WAIT) begin : g_err_wait
        $error("amba3_apb_slave_regs: WAIT_STATES exceeds APB_MAX_WAIT");
    end
    if (NUM_REGS < 1) begin : g_err_regs
        $error("amba3_apb_slave_regs: NUM_REGS must be at least 1");
    end

    amba3_apb_slave_state_t state_q, state_d;
    logic [APB_CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   write_q, write_d;
    logic [DATA_SIZE-1:0]   wdata_q, wdata_d;
    logic                   pready_q, pready_d;
    logic [DATA_SIZE-1:0]   prdata_q, prdata_d;
    logic                   pslverr_q, pslverr_d;
    logic [DATA_SIZE-1:0]   regs_q [NUM_REGS];

    logic                   setup_c;
    logic [IDX_W-1:0]       acc_idx_c;
    logic                   acc_write_c;
    logic                   acc_in_range_c;
    logic                   idx_in_range_c;
    logic [DATA_SIZE-1:0]   rd_data_c;
    logic                   wr_en_c;

    // Sub-word address bits carry no meaning for a word-wide register bank.
    if (LSB > 0) begin : g_addr_lsb
        logic unused_addr_lsb;
        assign unused_addr_lsb = ^paddr[LSB-1:0];
    end

    assign setup_c        = psel && !penable;
    // Entering DONE straight from IDLE must decode the live bus; otherwise use the latch.
    assign acc_idx_c      = (state_q == APB_S_IDLE) ? paddr[ADDR_SIZE-1:LSB] : idx_q;
    assign acc_write_c    = (state_q == APB_S_IDLE) ? pwrite : write_q;
    assign acc_in_range_c = acc_idx_c < IDX_W'(NUM_REGS);
    assign idx_in_range_c = idx_q < IDX_W'(NUM_REGS);

    always_comb begin
        rd_data_c = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (acc_idx_c == IDX_W'(i)) begin
                rd_data_c = regs_q[i];
            end
        end
    end

    // State register and latched transfer context.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q   <= APB_S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            pready_q  <= 1'b0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            pready_q  <= pready_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            APB_S_IDLE: begin
                if (setup_c) begin
                    state_d = (WAIT_STATES == 0) ? APB_S_DONE : APB_S_WAIT;
                end
            end
            APB_S_WAIT: begin
                if (!psel) begin
                    state_d = APB_S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = APB_S_DONE;
                end
            end
            APB_S_DONE: state_d = APB_S_IDLE;
            default:    state_d = APB_S_IDLE;
        endcase
    end

    // Output and datapath logic; response is registered on the edge entering DONE.
    always_comb begin
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        pready_d  = 1'b0;
        prdata_d  = '0;
        pslverr_d = 1'b0;
        wr_en_c   = 1'b0;

        unique case (state_q)
            APB_S_IDLE: begin
                if (setup_c) begin
                    idx_d   = paddr[ADDR_SIZE-1:LSB];
                    write_d = pwrite;
                    wdata_d = pwdata;
                    cnt_d   = APB_CNT_W'(CNT_LOAD);
                end
            end
            APB_S_WAIT: begin
                if (psel && cnt_q != '0) begin
                    cnt_d = cnt_q - APB_CNT_W'(1);
                end
            end
            APB_S_DONE: begin
                wr_en_c = psel && penable && write_q && idx_in_range_c;
            end
            default: ;
        endcase

        if (state_d == APB_S_DONE && state_q != APB_S_DONE) begin
            pready_d  = 1'b1;
            pslverr_d = !acc_in_range_c;
            prdata_d  = (!acc_write_c && acc_in_range_c) ? rd_data_c : '0;
        end
    end

    // Register bank, written only on the completion edge.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en_c) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    regs_q[i] <= wdata_q;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_o
        assign regs_o[g*DATA_SIZE +: DATA_SIZE] = regs_q[g];
    end

    assign pready  = pready_q;
    assign prdata  = prdata_q;
    assign pslverr = pslverr_q;

endmodule

// File: tb/tb_amba3_apb_slave_regs.sv
// Self-checking bench: three completers (0, 3 and 2 wait states) against a
// word-array reference model.
module tb_amba3_apb_slave_regs;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned NR = 16;
    localparam int unsigned ND = 3;

    logic                pclk = 1'b0;
    logic                preset;
    logic [AW-1:0]       paddr;
    logic [DW-1:0]       pwdata;
    logic                penable;
    logic                pwrite;
    logic [ND-1:0]       psel;
    logic [ND-1:0]       pready;
    logic [ND-1:0]       pslverr;
    logic [DW-1:0]       prdata [ND];
    logic [NR*DW-1:0]    regs   [ND];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [DW-1:0] model [ND][NR];

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc++;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        amba3_apb_slave_regs #(
            .ADDR_SIZE  (AW),
            .DATA_SIZE  (DW),
            .NUM_REGS   (NR),
            .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 3 : 2))
        ) u_dut (
            .pclk    (pclk),
            .preset  (preset),
            .paddr   (paddr),
            .psel    (psel[g]),
            .penable (penable),
            .pwrite  (pwrite),
            .pwdata  (pwdata),
            .pready  (pready[g]),
            .prdata  (prdata[g]),
            .pslverr (pslverr[g]),
            .regs_o  (regs[g])
        );
    end

    function automatic int ws_of(input int d);
        if (d == 0) return 0;
        if (d == 1) return 3;
        return 2;
    endfunction

    function automatic logic [NR*DW-1:0] exp_regs(input int d);
        logic [NR*DW-1:0] v;
        for (int i = 0; i < NR; i++) v[i*DW +: DW] = model[d][i];
        return v;
    endfunction

    // Reference: byte address -> word index, out-of-range gives error and no effect.
    function automatic void model_xfer(input int d, input logic [AW-1:0] addr, input logic wr,
                                       input logic [DW-1:0] wdata, output logic [DW-1:0] exp_rd,
                                       output logic exp_err);
        int unsigned idx;
        idx     = addr / 4;
        exp_err = (idx >= NR);
        exp_rd  = '0;
        if (!exp_err) begin
            if (wr) model[d][idx] = wdata;
            else    exp_rd = model[d][idx];
        end
    endfunction

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // One full transfer; address/data are scrambled after setup to prove they are latched.
    task automatic apb_xfer(input int d, input logic [AW-1:0] addr, input logic wr,
                            input logic [DW-1:0] wdata, output int acc_cycles,
                            output logic [DW-1:0] rdata, output logic err,
                            output logic wait_dirty, output logic after_ready);
        paddr   = addr;
        pwrite  = wr;
        pwdata  = wdata;
        psel    = '0;
        psel[d] = 1'b1;
        penable = 1'b0;
        tick();
        penable    = 1'b1;
        paddr      = $urandom;
        pwdata     = $urandom;
        acc_cycles = 1;
        wait_dirty = 1'b0;
        while (pready[d] !== 1'b1 && acc_cycles <= 40) begin
            if (prdata[d] !== '0 || pslverr[d] !== 1'b0) wait_dirty = 1'b1;
            tick();
            acc_cycles++;
        end
        rdata = prdata[d];
        err   = pslverr[d];
        tick();
        after_ready = pready[d];
        psel    = '0;
        penable = 1'b0;
    endtask

    task automatic test_reset();
        preset  = 1'b1;
        psel    = '0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        for (int d = 0; d < ND; d++) for (int i = 0; i < NR; i++) model[d][i] = '0;
        tick();
        tick();
        for (int d = 0; d < ND; d++) begin
            checks++;
            if (pready[d] !== 1'b0 || pslverr[d] !== 1'b0 || prdata[d] !== '0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: pready=%b pslverr=%b prdata=%h, expected 0/0/0",
                         d, pready[d], pslverr[d], prdata[d]);
            end
            checks++;
            if (regs[d] !== exp_regs(d)) begin
                errors++;
                $display("FAIL reset_regs dut%0d: got %h expected %h", d, regs[d], exp_regs(d));
            end
        end
        preset = 1'b0;
        tick();

        // Reset during the second access cycle of a 3-wait-state write.
        paddr = 32'h8; pwrite = 1'b1; pwdata = 32'hCAFEF00D; psel = 3'b010;
        tick();
        penable = 1'b1;
        tick();
        #2 preset = 1'b1;
        #1;
        checks++;
        if (pready[1] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_wait pready: got %b expected 0", pready[1]);
        end
        psel = '0; penable = 1'b0;
        tick();
        preset = 1'b0;
        tick();
        checks++;
        if (regs[1] !== exp_regs(1)) begin
            errors++;
            $display("FAIL reset_mid_wait regs: got %h expected %h", regs[1], exp_regs(1));
        end

        // Reset while pready is high, before the completion edge.
        paddr = 32'h4; pwrite = 1'b1; pwdata = 32'h55; psel = 3'b001;
        tick();
        checks++;
        if (pready[0] !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_done pready: got %b expected 1", pready[0]);
        end
        penable = 1'b1;
        #2 preset = 1'b1;
        #1;
        checks++;
        if (pready[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_done pready: got %b expected 0", pready[0]);
        end
        tick();
        psel = '0; penable = 1'b0; preset = 1'b0;
        tick();
        checks++;
        if (regs[0] !== exp_regs(0)) begin
            errors++;
            $display("FAIL reset_in_done regs: got %h expected %h", regs[0], exp_regs(0));
        end
    endtask

    task automatic test_basic_ws0();
        int n; logic [DW-1:0] rd, erd; logic er, eer, dirty, aft;
        model_xfer(0, 32'h10, 1'b1, 32'hDEADBEEF, erd, eer);
        apb_xfer(0, 32'h10, 1'b1, 32'hDEADBEEF, n, rd, er, dirty, aft);
        checks++;
        if (n !== 1 || er !== 1'b0 || aft !== 1'b0) begin
            errors++;
            $display("FAIL ws0_write: cycles=%0d err=%b after=%b expected 1/0/0", n, er, aft);
        end
        checks++;
        if (regs[0][4*DW +: DW] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL ws0_reg4: got %h expected deadbeef", regs[0][4*DW +: DW]);
        end
        model_xfer(0, 32'h10, 1'b0, '0, erd, eer);
        apb_xfer(0, 32'h10, 1'b0, '0, n, rd, er, dirty, aft);
        checks++;
        if (n !== 1 || rd !== erd || er !== eer) begin
            errors++;
            $display("FAIL ws0_read: cycles=%0d prdata=%h err=%b expected 1/%h/%b", n, rd, er, erd, eer);
        end
    endtask

    task automatic test_wait_states();
        int n; logic [DW-1:0] rd, erd, v; logic er, eer, dirty, aft;
        model_xfer(1, 32'h0, 1'b0, '0, erd, eer);
        apb_xfer(1, 32'h0, 1'b0, '0, n, rd, er, dirty, aft);
        checks++;
        if (n !== 4 || dirty !== 1'b0 || aft !== 1'b0 || rd !== erd) begin
            errors++;
            $display("FAIL ws3_read0: cycles=%0d dirty=%b after=%b prdata=%h expected 4/0/0/%h",
                     n, dirty, aft, rd, erd);
        end
        v = $urandom;
        model_xfer(1, 32'h3C, 1'b1, v, erd, eer);
        apb_xfer(1, 32'h3C, 1'b1, v, n, rd, er, dirty, aft);
        model_xfer(1, 32'h3C, 1'b0, '0, erd, eer);
        apb_xfer(1, 32'h3C, 1'b0, '0, n, rd, er, dirty, aft);
        checks++;
        if (n !== 4 || rd !== erd || dirty !== 1'b0) begin
            errors++;
            $display("FAIL ws3_read15: cycles=%0d prdata=%h dirty=%b expected 4/%h/0", n, rd, dirty, erd);
        end
    endtask

    task automatic test_out_of_range();
        int n; logic [DW-1:0] rd, erd; logic er, eer, dirty, aft;
        model_xfer(0, 32'h40, 1'b1, 32'h1234, erd, eer);
        apb_xfer(0, 32'h40, 1'b1, 32'h1234, n, rd, er, dirty, aft);
        checks++;
        if (n !== 1 || er !== 1'b1 || regs[0] !== exp_regs(0)) begin
            errors++;
            $display("FAIL oor_write: cycles=%0d err=%b regs=%h expected 1/1/%h", n, er, regs[0], exp_regs(0));
        end
        model_xfer(0, 32'h40, 1'b0, '0, erd, eer);
        apb_xfer(0, 32'h40, 1'b0, '0, n, rd, er, dirty, aft);
        checks++;
        if (rd !== '0 || er !== 1'b1 || aft !== 1'b0) begin
            errors++;
            $display("FAIL oor_read: prdata=%h err=%b after=%b expected 0/1/0", rd, er, aft);
        end
        apb_xfer(1, 32'h44, 1'b0, '0, n, rd, er, dirty, aft);
        checks++;
        if (n !== 4 || er !== 1'b1 || rd !== '0 || dirty !== 1'b0) begin
            errors++;
            $display("FAIL oor_ws3: cycles=%0d err=%b prdata=%h dirty=%b expected 4/1/0/0", n, er, rd, dirty);
        end
    endtask

    task automatic test_back_to_back();
        int n, c0; logic [DW-1:0] rd, erd; logic er, eer, dirty, aft;
        c0 = cyc;
        for (int k = 0; k < 3; k++) begin
            model_xfer(0, AW'(k * 4), 1'b1, DW'(k + 1), erd, eer);
            apb_xfer(0, AW'(k * 4), 1'b1, DW'(k + 1), n, rd, er, dirty, aft);
        end
        checks++;
        if (cyc - c0 !== 6) begin
            errors++;
            $display("FAIL b2b_cycles: got %0d expected 6", cyc - c0);
        end
        checks++;
        if (regs[0] !== exp_regs(0)) begin
            errors++;
            $display("FAIL b2b_regs: got %h expected %h", regs[0], exp_regs(0));
        end
        model_xfer(0, 32'h5, 1'b1, 32'hAA, erd, eer);
        apb_xfer(0, 32'h5, 1'b1, 32'hAA, n, rd, er, dirty, aft);
        checks++;
        if (regs[0][1*DW +: DW] !== 32'hAA || er !== 1'b0) begin
            errors++;
            $display("FAIL unaligned_write: reg1=%h err=%b expected 000000aa/0", regs[0][1*DW +: DW], er);
        end
        model_xfer(0, 32'h6, 1'b0, '0, erd, eer);
        apb_xfer(0, 32'h6, 1'b0, '0, n, rd, er, dirty, aft);
        checks++;
        if (rd !== erd) begin
            errors++;
            $display("FAIL unaligned_read: got %h expected %h", rd, erd);
        end
    endtask

    task automatic test_abort();
        int n; logic seen; logic [DW-1:0] rd, erd; logic er, eer, dirty, aft;
        seen  = 1'b0;
        paddr = 32'h20; pwrite = 1'b1; pwdata = 32'h0BADF00D; psel = 3'b100; penable = 1'b0;
        tick();
        penable = 1'b1;
        seen |= pready[2];
        tick();
        seen |= pready[2];
        psel = '0; penable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            seen |= pready[2];
        end
        checks++;
        if (seen !== 1'b0 || regs[2] !== exp_regs(2)) begin
            errors++;
            $display("FAIL abort: pready_seen=%b regs=%h expected 0/%h", seen, regs[2], exp_regs(2));
        end
        model_xfer(2, 32'h20, 1'b0, '0, erd, eer);
        apb_xfer(2, 32'h20, 1'b0, '0, n, rd, er, dirty, aft);
        checks++;
        if (n !== 3 || rd !== erd || er !== 1'b0) begin
            errors++;
            $display("FAIL abort_recover: cycles=%0d prdata=%h err=%b expected 3/%h/0", n, rd, er, erd);
        end
    endtask

    task automatic test_penable_idle();
        logic seen;
        seen  = 1'b0;
        paddr = 32'h0; pwrite = 1'b1; pwdata = 32'hFFFF0000; psel = 3'b001; penable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            seen |= pready[0];
        end
        psel = '0; penable = 1'b0;
        tick();
        seen |= pready[0];
        checks++;
        if (seen !== 1'b0 || regs[0] !== exp_regs(0)) begin
            errors++;
            $display("FAIL penable_idle: pready_seen=%b regs=%h expected 0/%h", seen, regs[0], exp_regs(0));
        end
    endtask

    task automatic test_random();
        int n, d; logic [AW-1:0] a; logic w; logic [DW-1:0] v, rd, erd; logic er, eer, dirty, aft;
        for (int t = 0; t < 80; t++) begin
            d = int'($urandom_range(0, ND - 1));
            a = AW'($urandom_range(0, 127));
            w = 1'($urandom_range(0, 1));
            v = $urandom;
            model_xfer(d, a, w, v, erd, eer);
            apb_xfer(d, a, w, v, n, rd, er, dirty, aft);
            checks++;
            if (n !== 1 + ws_of(d) || rd !== erd || er !== eer || dirty !== 1'b0 || aft !== 1'b0) begin
                errors++;
                $display("FAIL rand_xfer t=%0d dut%0d addr=%h wr=%b: cycles=%0d prdata=%h err=%b dirty=%b after=%b expected %0d/%h/%b/0/0",
                         t, d, a, w, n, rd, er, dirty, aft, 1 + ws_of(d), erd, eer);
            end
            checks++;
            if (regs[d] !== exp_regs(d)) begin
                errors++;
                $display("FAIL rand_regs t=%0d dut%0d: got %h expected %h", t, d, regs[d], exp_regs(d));
            end
            if ($urandom_range(0, 3) == 0) tick();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic_ws0();
        test_wait_states();
        test_out_of_range();
        test_back_to_back();
        test_abort();
        test_penable_idle();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
